// File: rtl/snow64_instr_issue_scheduler_pkg.sv
// Shared types and constants for the Snow64 instruction issue scheduler.
package PkgSnow64IssueSched;

  localparam int REG_IDX_W = 4;

  // Decoder instruction groups; the scheduler steers on this field alone.
  typedef enum logic [1:0] {
    IgAlu   = 2'd0,
    IgCtrl  = 2'd1,
    IgLoad  = 2'd2,
    IgStore = 2'd3
  } InstrGroup;

  // Opcode values used by the scheduler's neighbours; oper is group-relative.
  localparam logic [3:0] OpAdd       = 4'h0;
  localparam logic [3:0] OpSub       = 4'h1;
  localparam logic [3:0] OpBad0_Iog0 = 4'hf;
  localparam logic [3:0] OpBtru      = 4'h2;
  localparam logic [3:0] OpLdU8      = 4'h0;

  typedef struct packed {
    logic                 nop;
    InstrGroup            group;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic [3:0]           oper;
    logic [15:0]          imm;
  } PortOut_InstrDecoder;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StHold     = 2'd1,
    StWaitCtrl = 2'd2
  } IssueSchedState;

  typedef enum logic [1:0] {
    UnitAlu  = 2'd0,
    UnitCtrl = 2'd1,
    UnitLsu  = 2'd2
  } ExecUnit;

  // Tables indexed by the InstrGroup value (bit n = group n).
  localparam ExecUnit    GROUP_UNIT [4]   = '{UnitAlu, UnitCtrl, UnitLsu, UnitLsu};
  localparam logic [3:0] GROUP_WRITES_RA  = 4'b0101;
  localparam logic [3:0] GROUP_READS_RA   = 4'b1010;
  localparam logic [3:0] GROUP_READS_RBRC = 4'b1101;

endpackage

// File: rtl/snow64_reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue of a
// writing instruction and cleared on writeback. Lookups see registered state.
module snow64_reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_valid,
  input  logic [IDX_W-1:0]    set_index,
  input  logic                clr_valid,
  input  logic [IDX_W-1:0]    clr_index,
  input  logic [IDX_W-1:0]    rd_a_index,
  input  logic [IDX_W-1:0]    rd_b_index,
  input  logic [IDX_W-1:0]    rd_c_index,
  input  logic [IDX_W-1:0]    wr_index,
  output logic [NUM_REGS-1:0] busy,
  output logic                rd_a_busy,
  output logic                rd_b_busy,
  output logic                rd_c_busy,
  output logic                wr_busy
);

  // Busy bits: clear on writeback, set on issue; different indices both land.
  // NOTE: the busy bits are ordinary flops that must read clear after reset, so
  // they are reset like any other state rather than treated as an unreset RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so the later set cannot be observed by the clear within the same edge.
      if (clr_valid) busy[clr_index] <= 1'b0;
      if (set_valid) busy[set_index] <= 1'b1;
    end
  end

  assign rd_a_busy = busy[rd_a_index];
  assign rd_b_busy = busy[rd_b_index];
  assign rd_c_busy = busy[rd_c_index];
  assign wr_busy   = busy[wr_index];

endmodule

// File: rtl/snow64_instr_issue_scheduler.sv
// One-entry issue stage: holds a decoded instruction, checks it against the
// register scoreboard and offers it to the ALU, branch unit or LSU.
import PkgSnow64IssueSched::*;

module snow64_instr_issue_scheduler #(
  parameter int NUM_REGS       = 16,
  parameter int WIDTH__PERFCNT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_dec_valid,
  output logic                        out_dec_ready,
  input  PortOut_InstrDecoder         in_dec,
  output logic                        out_alu_valid,
  input  logic                        in_alu_ready,
  output logic                        out_ctrl_valid,
  input  logic                        in_ctrl_ready,
  output logic                        out_lsu_valid,
  input  logic                        in_lsu_ready,
  output PortOut_InstrDecoder         out_issue_instr,
  input  logic                        in_ctrl_done,
  input  logic                        in_ctrl_flush,
  input  logic                        in_wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] in_wb_index,
  output logic [WIDTH__PERFCNT-1:0]   out_stall_cycles
);

  localparam int IDX_W = $clog2(NUM_REGS);

  IssueSchedState      state, state_next;
  PortOut_InstrDecoder held_instr;
  ExecUnit             held_unit;
  logic                reads_ra, reads_rbrc, writes_ra;
  logic                ra_busy, rb_busy, rc_busy, wr_busy;
  logic                hazard, issue_ok, handshake, retire, retire_to_ctrl;
  logic                dec_accept, set_valid;
  logic [NUM_REGS-1:0] busy_unused;

  assign held_unit  = GROUP_UNIT[held_instr.group];
  assign reads_ra   = GROUP_READS_RA[held_instr.group];
  assign reads_rbrc = GROUP_READS_RBRC[held_instr.group];
  assign writes_ra  = GROUP_WRITES_RA[held_instr.group];

  snow64_reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_valid  (set_valid),
    .set_index  (held_instr.ra),
    .clr_valid  (in_wb_valid),
    .clr_index  (in_wb_index),
    .rd_a_index (held_instr.ra),
    .rd_b_index (held_instr.rb),
    .rd_c_index (held_instr.rc),
    .wr_index   (held_instr.ra),
    .busy       (busy_unused),
    .rd_a_busy  (ra_busy),
    .rd_b_busy  (rb_busy),
    .rd_c_busy  (rc_busy),
    .wr_busy    (wr_busy)
  );

  // Hazard: any register the held instruction touches is still in flight.
  assign hazard   = (reads_ra & ra_busy) | (reads_rbrc & (rb_busy | rc_busy))
                  | (writes_ra & wr_busy);
  assign issue_ok = (state == StHold) & ~held_instr.nop & ~hazard;

  assign handshake      = (out_alu_valid & in_alu_ready) | (out_ctrl_valid & in_ctrl_ready)
                        | (out_lsu_valid & in_lsu_ready);
  // A nop retires from HOLD on its own and counts as a handshake for accept.
  assign retire         = (state == StHold) & (held_instr.nop | handshake);
  assign retire_to_ctrl = handshake & (held_unit == UnitCtrl);
  assign dec_accept     = in_dec_valid & out_dec_ready;
  assign set_valid      = handshake & writes_ra;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= StIdle;
    else     state <= state_next;
  end

  // Next state, unit valids and decoder ready.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next     = state;
    out_alu_valid  = issue_ok & (held_unit == UnitAlu);
    out_ctrl_valid = issue_ok & (held_unit == UnitCtrl);
    out_lsu_valid  = issue_ok & (held_unit == UnitLsu);
    out_dec_ready  = 1'b0;
    unique case (state)
      StIdle: begin
        out_dec_ready = ~rst;
        if (dec_accept) state_next = StHold;
      end
      StHold: begin
        out_dec_ready = ~rst & retire & ~retire_to_ctrl;
        if (retire_to_ctrl)  state_next = StWaitCtrl;
        else if (retire)     state_next = dec_accept ? StHold : StIdle;
      end
      StWaitCtrl: begin
        // Both exits land in IDLE: the decoder refetches after a redirect, and
        // nothing is held here that a flush would have to discard.
        if (in_ctrl_done) begin
          if (in_ctrl_flush) state_next = StIdle;
          else               state_next = StIdle;
        end
      end
      default: state_next = StIdle;
    endcase
  end

  // Issue register: loaded on accept, stable while a unit valid is up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             held_instr <= '0;
    else if (dec_accept) held_instr <= in_dec;
  end

  // Saturating count of HOLD cycles that end without a retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_stall_cycles <= '0;
    end else if ((state == StHold) && !retire && (out_stall_cycles != '1)) begin
      out_stall_cycles <= out_stall_cycles + WIDTH__PERFCNT'(1);
    end
  end

  assign out_issue_instr = held_instr;

endmodule
